mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15; wait cycles for mem_ack before the access is aborted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents an access.
REQ-005 req_ready  output  1  controller accepts an access this cycle.
REQ-006 opcode  input  6  access opcode:
- 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu
- 0x28 sb, 0x29 sh, 0x2B sw
REQ-007 base  input  32  base address register value.
REQ-008 offset  input  16  signed immediate offset.
REQ-009 store_data  input  32  data for store opcodes.
REQ-010 resp_valid  output  1  one-cycle pulse; access complete.
REQ-011 load_data  output  32  extended load result, valid with resp_valid.
REQ-012 resp_err  output  1  valid with resp_valid; 1 = timeout or illegal opcode.
REQ-013 mem_address  output  32  address to data memory.
REQ-014 mem_write_data  output  32  write data to data memory.
REQ-015 mem_opcode  output  6  opcode forwarded to data memory for sub-word store selection.
REQ-016 MemRead  output  1  read strobe to data memory.
REQ-017 MemWrite  output  1  write strobe to data memory.
REQ-018 mem_read_data  input  32  word returned by data memory.
REQ-019 mem_ack  input  1  data memory completed the current access.

Function
REQ-020 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-021 IDLE SHALL drive req_ready=1; all other states drive req_ready=0.
REQ-022 A request SHALL be accepted when req_valid=1 in IDLE.
REQ-023 On acceptance the controller SHALL register opcode, store_data and mem_address.
- mem_address = base + sign_extend(offset), modulo 2^32; no overflow flag.
REQ-024 Acceptance of a legal opcode SHALL move the FSM to ACCESS.
REQ-025 Acceptance of an illegal opcode SHALL move the FSM to RESP with resp_err=1, MemRead=MemWrite=0 throughout.
REQ-026 In ACCESS, strobes SHALL be held stable until exit:
- loads: MemRead=1, MemWrite=0
- stores: MemWrite=1, MemRead=0, mem_write_data=store_data
REQ-027 In ACCESS, a wait counter SHALL start at 0 and increment each cycle mem_ack=0.
REQ-028 mem_ack=1 in ACCESS SHALL capture the result and move the FSM to RESP with resp_err=0.
- lb: sign-extend mem_read_data[7:0]; lbu: zero-extend [7:0]
- lh: sign-extend [15:0]; lhu: zero-extend [15:0]
- lw: full word
- stores: load_data=0
REQ-029 If the counter reaches TIMEOUT with mem_ack still 0, the FSM SHALL move to RESP with resp_err=1 and load_data=0.
REQ-030 mem_ack=1 on the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-031 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-032 Strobes SHALL be 0 in IDLE and RESP.
REQ-033 mem_ack outside ACCESS SHALL be ignored.
REQ-034 Minimum latency SHALL be 2 cycles from acceptance edge to resp_valid (mem_ack in first ACCESS cycle).
REQ-035 Back-to-back throughput SHALL be one access per 3 cycles minimum.

Reset
REQ-036 Reset SHALL force the FSM to IDLE and clear the wait counter.
REQ-037 Reset SHALL clear all outputs to 0 except req_ready, which SHALL be 1.
REQ-038 Reset asserted mid-ACCESS SHALL drop strobes immediately (asynchronously) and produce no resp_valid for the aborted access.

Verification
REQ-039 lw, base=0x10, offset=0xFFFC, mem_read_data=0x8000_00F0, ack on cycle 1 -> mem_address=0x0C, MemRead=1, resp_valid 2 cycles after accept, load_data=0x8000_00F0, resp_err=0.
REQ-040 lb then lbu, mem_read_data=0x0000_0080 -> load_data=0xFFFF_FF80, then 0x0000_0080.
REQ-041 sh, base=0xFFFF_FFFF, offset=1, store_data=0x1234_ABCD -> mem_address=0x0000_0000 (wrap), MemWrite=1, mem_opcode=0x29, mem_write_data=0x1234_ABCD.
REQ-042 lw with mem_ack held 0 -> resp_valid with resp_err=1 and load_data=0 after TIMEOUT wait cycles; req_ready=1 the next cycle.
REQ-043 opcode=0x3F -> no strobes, resp_valid with resp_err=1 one cycle after accept.
REQ-044 reset pulse in the second ACCESS cycle -> strobes 0 at once, no resp_valid, req_ready=1; next lw completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: computes the effective address, strobes the data
// memory until it acknowledges or the wait budget expires, then returns one response.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] base,
    input  logic [15:0] offset,
    input  logic [31:0] store_data,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [5:0]  mem_opcode,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE. resp_valid is a one-cycle pulse with no back-pressure.

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt;
    logic           op_is_load, op_is_store, in_is_legal, timed_out;
    logic [31:0]    ext_data;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    assign op_is_load  = is_load(mem_opcode);
    assign op_is_store = is_store(mem_opcode);
    assign in_is_legal = is_load(opcode) || is_store(opcode);
    // Ack on the very cycle the budget runs out still counts as success.
    assign timed_out   = (wait_cnt == CW'(TIMEOUT)) && !mem_ack;

    always_comb begin
        ext_data = 32'h0;
        case (mem_opcode)
            OP_LB:   ext_data = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            OP_LBU:  ext_data = {24'h0, mem_read_data[7:0]};
            OP_LH:   ext_data = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            OP_LHU:  ext_data = {16'h0, mem_read_data[15:0]};
            OP_LW:   ext_data = mem_read_data;
            default: ext_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = in_is_legal ? ACCESS : RESP;
            end
            ACCESS: begin
                if (mem_ack || timed_out) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wait_cnt       <= '0;
            mem_opcode     <= 6'h0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
            load_data      <= 32'h0;
            resp_err       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_opcode     <= opcode;
                        mem_address    <= base + {{16{offset[15]}}, offset};
                        mem_write_data <= store_data;
                        wait_cnt       <= '0;
                        load_data      <= 32'h0;
                        resp_err       <= !in_is_legal;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        load_data <= ext_data;
                        resp_err  <= 1'b0;
                    end else if (timed_out) begin
                        load_data <= 32'h0;
                        resp_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign MemRead    = (state_q == ACCESS) && op_is_load;
    assign MemWrite   = (state_q == ACCESS) && op_is_store;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: drivers push expectations, monitors on the
// falling edge pop and compare responses and memory-side strobes.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] base = 32'h0;
    logic [15:0] offset = 16'h0;
    logic [31:0] store_data = 32'h0;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [5:0]  mem_opcode;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_ack = 1'b0;
    logic [1:0]  dbg_state;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .base(base), .offset(offset), .store_data(store_data),
        .resp_valid(resp_valid), .load_data(load_data), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_opcode(mem_opcode), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_read_data(mem_read_data), .mem_ack(mem_ack), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] ld;
        logic        err;
        int          cyc;
    } resp_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  op;
        logic        rd;
        logic        wr;
    } mem_exp_t;

    resp_exp_t resp_exp_q[$];
    mem_exp_t  mem_exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    logic prev_resp = 1'b0;
    always @(negedge clk) begin
        resp_exp_t e;
        if (!reset) begin
            if (prev_resp) begin
                check("ready_after_resp", {63'h0, req_ready}, 64'h1);
                check("resp_one_cycle", {63'h0, resp_valid}, 64'h0);
            end
            if (resp_valid) begin
                if (resp_exp_q.size() == 0) begin
                    check("resp_unexpected", 64'h1, 64'h0);
                end else begin
                    e = resp_exp_q.pop_front();
                    check("load_data", {32'h0, load_data}, {32'h0, e.ld});
                    check("resp_err", {63'h0, resp_err}, {63'h0, e.err});
                    check("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_resp = resp_valid;
        end else begin
            prev_resp = 1'b0;
        end
    end

    logic     strobe_prev = 1'b0;
    mem_exp_t cur;
    always @(negedge clk) begin
        if (!reset && (MemRead || MemWrite)) begin
            if (!strobe_prev) begin
                if (mem_exp_q.size() == 0) begin
                    check("strobe_unexpected", 64'h1, 64'h0);
                end else begin
                    cur = mem_exp_q.pop_front();
                    check("mem_address", {32'h0, mem_address}, {32'h0, cur.addr});
                    check("mem_opcode", {58'h0, mem_opcode}, {58'h0, cur.op});
                    check("strobes", {62'h0, MemRead, MemWrite}, {62'h0, cur.rd, cur.wr});
                    if (cur.wr)
                        check("mem_write_data", {32'h0, mem_write_data}, {32'h0, cur.wdata});
                end
            end else begin
                check("strobe_stable", {30'h0, MemRead, MemWrite, mem_address},
                      {30'h0, cur.rd, cur.wr, cur.addr});
            end
        end
        strobe_prev = !reset && (MemRead || MemWrite);
    end

    // ---------------- drivers ----------------
    // ack_at: index of the ACCESS cycle (0 = first) in which mem_ack is driven; -1 = never.
    task automatic issue(input logic [5:0] op, input logic [31:0] b, input logic [15:0] off,
                         input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                         input logic [31:0] exp_addr, input logic exp_rd, input logic exp_wr,
                         input logic [31:0] exp_ld, input logic exp_err, input int exp_lat);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_wait_expired", 64'h0, 64'h1);
            return;
        end
        resp_exp_q.push_back('{ld: exp_ld, err: exp_err, cyc: cyc + exp_lat});
        if (exp_rd || exp_wr)
            mem_exp_q.push_back('{addr: exp_addr, wdata: sd, op: op, rd: exp_rd, wr: exp_wr});
        req_valid     = 1'b1;
        opcode        = op;
        base          = b;
        offset        = off;
        store_data    = sd;
        mem_read_data = rd;
        mem_ack       = 1'b0;
        @(negedge clk);
        req_valid  = 1'b0;
        opcode     = 6'($urandom_range(0, 63));
        base       = $urandom;
        offset     = 16'($urandom_range(0, 65535));
        store_data = $urandom;
        n = 0;
        while (!req_ready && n < 40) begin
            mem_ack = (n == ack_at);
            @(negedge clk);
            n++;
        end
        mem_ack = 1'b0;
        if (!req_ready) check("resp_wait_expired", 64'h0, 64'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #3;
        check("rst_req_ready", {63'h0, req_ready}, 64'h1);
        check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        check("rst_strobes", {62'h0, MemRead, MemWrite}, 64'h0);
        check("rst_outputs", {load_data, mem_address}, 64'h0);
        check("rst_misc", {25'h0, resp_err, mem_opcode, mem_write_data}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        //     op     base          off      store         mem_rd        ack  addr          rd wr  load          err lat
        issue(6'h23, 32'h00000010, 16'hFFFC, 32'h0,        32'h800000F0, 0,   32'h0000000C, 1, 0, 32'h800000F0, 0, 2);
        issue(6'h20, 32'h00000100, 16'h0004, 32'h0,        32'h00000080, 0,   32'h00000104, 1, 0, 32'hFFFFFF80, 0, 2);
        issue(6'h24, 32'h00000100, 16'h0004, 32'h0,        32'h00000080, 0,   32'h00000104, 1, 0, 32'h00000080, 0, 2);
        issue(6'h29, 32'hFFFFFFFF, 16'h0001, 32'h1234ABCD, 32'h55555555, 2,   32'h00000000, 0, 1, 32'h00000000, 0, 4);
        issue(6'h21, 32'h00002000, 16'h8000, 32'h0,        32'h00008001, 1,   32'hFFFFA000, 1, 0, 32'hFFFF8001, 0, 3);
        issue(6'h25, 32'h00000040, 16'h7FFF, 32'h0,        32'hABCD8001, 0,   32'h0000803F, 1, 0, 32'h00008001, 0, 2);
        issue(6'h28, 32'h00001000, 16'h0003, 32'hDEADBEEF, 32'h0,        0,   32'h00001003, 0, 1, 32'h00000000, 0, 2);
        issue(6'h2B, 32'h00000008, 16'hFFF8, 32'hCAFEF00D, 32'hFFFFFFFF, 0,   32'h00000000, 0, 1, 32'h00000000, 0, 2);
        issue(6'h23, 32'h00000044, 16'h0000, 32'h0,        32'h00000055, -1,  32'h00000044, 1, 0, 32'h00000000, 1, 2 + TIMEOUT);
        issue(6'h23, 32'h00000048, 16'h0000, 32'h0,        32'h12345678, TIMEOUT, 32'h00000048, 1, 0, 32'h12345678, 0, 2 + TIMEOUT);
        issue(6'h3F, 32'h00000010, 16'h0000, 32'h0,        32'h0,        0,   32'h0,        0, 0, 32'h00000000, 1, 1);
        issue(6'h22, 32'h00000020, 16'h0000, 32'h0,        32'h0,        -1,  32'h0,        0, 0, 32'h00000000, 1, 1);
        issue(6'h21, 32'h00000200, 16'h0002, 32'h0,        32'h00017FFF, 0,   32'h00000202, 1, 0, 32'h00007FFF, 0, 2);

        // Reset in the second ACCESS cycle of a load: strobes vanish, no response follows.
        mem_exp_q.push_back('{addr: 32'h00000030, wdata: 32'h0, op: 6'h23, rd: 1'b1, wr: 1'b0});
        req_valid = 1'b1;
        opcode    = 6'h23;
        base      = 32'h00000030;
        offset    = 16'h0000;
        mem_ack   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_strobes", {62'h0, MemRead, MemWrite}, 64'h0);
        check("rst_mid_ready", {63'h0, req_ready}, 64'h1);
        check("rst_mid_resp", {63'h0, resp_valid}, 64'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        issue(6'h23, 32'h00000030, 16'h0004, 32'h0,        32'hA5A5A5A5, 0,   32'h00000034, 1, 0, 32'hA5A5A5A5, 0, 2);

        repeat (4) @(negedge clk);
        check("resp_q_empty", 64'(resp_exp_q.size()), 64'h0);
        check("mem_q_empty", 64'(mem_exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
